// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and default frame constants for the sequence transmitter and detectors
package seq_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_t;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_GAP = 1;
endpackage

// File: rtl/seq_shift_out.sv
// seq_shift_out: loadable shift register whose serial output bit is registered
// ports: clk, rst_n (sync active-low), clr (zero register and dout), load (capture din, emit its first bit),
//        shift (emit next bit), din (parallel word), dout (registered serial bit)
module seq_shift_out #(
    parameter int WIDTH = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] nxt;
    logic             head;
    // On load the first bit goes straight to dout, so the register keeps only the remaining bits.
    always_comb begin
        src  = load ? din : sr;
        head = MSB_FIRST ? src[WIDTH-1] : src[0];
        nxt  = MSB_FIRST ? {src[WIDTH-2:0], 1'b0} : {1'b0, src[WIDTH-1:1]};
    end
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            sr   <= '0;
            dout <= 1'b0;
        end else if (load || shift) begin
            sr   <= nxt;
            dout <= head;
        end
    end
endmodule

// File: rtl/seq_bit_tx.sv
// seq_bit_tx: serial sequence transmitter, parallel word in by valid/ready, one bit per clock out on C
// ports: clk, rst_n (sync active-low), data_in/data_valid/data_ready (word handshake, ready only in idle),
//        abort (cancel current frame), C (registered serial bit), c_valid (C holds a frame bit),
//        frame_done (pulse with the last bit of a frame)
module seq_bit_tx
    import seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP = DEF_GAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    input  logic             abort,
    output logic             data_ready,
    output logic             C,
    output logic             c_valid,
    output logic             frame_done
);
    localparam int CW = $clog2(WIDTH);
    localparam int GW = GAP > 0 ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] C_PEN = CW'(WIDTH - 2);
    localparam logic [GW-1:0] G_LAST = GW'(GAP > 0 ? GAP - 1 : 0);
    tx_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [GW-1:0] gcnt, gcnt_nxt;
    logic          hs, last, adv, cv_nxt, fd_nxt;
    assign data_ready = state == ST_IDLE;
    // adv: a further frame bit is emitted at this edge; cv_nxt covers both the first bit and later ones.
    always_comb begin
        hs        = state == ST_IDLE && data_valid && !abort;
        last      = cnt == C_LAST;
        adv       = state == ST_SHIFT && !abort && !last;
        cv_nxt    = hs || adv;
        fd_nxt    = adv && cnt == C_PEN;
        cnt_nxt   = hs ? '0 : adv ? cnt + 1'b1 : cnt;
        gcnt_nxt  = state == ST_GAP ? gcnt + 1'b1 : '0;
        state_nxt = abort               ? ST_IDLE :
                    state == ST_IDLE    ? (hs ? ST_SHIFT : ST_IDLE) :
                    state == ST_SHIFT   ? (last ? (GAP > 0 ? ST_GAP : ST_IDLE) : ST_SHIFT) :
                    state == ST_GAP     ? (gcnt == G_LAST ? ST_IDLE : ST_GAP) :
                    ST_IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            gcnt       <= '0;
            c_valid    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            gcnt       <= gcnt_nxt;
            c_valid    <= cv_nxt;
            frame_done <= fd_nxt;
        end
    end
    // Clearing whenever no bit is due keeps C at 0 outside frames.
    seq_shift_out #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_shift (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (!cv_nxt),
        .load (hs),
        .shift(adv),
        .din  (data_in),
        .dout (C)
    );
endmodule

// File: tb/tb_seq_bit_tx.sv
// tb_seq_bit_tx: scoreboard bench for seq_bit_tx, one MSB-first GAP=2 instance and one LSB-first GAP=0 instance
module tb_seq_bit_tx;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din [2];
    logic       dv [2];
    logic       ab [2];
    logic       dr [2];
    logic       c [2];
    logic       cv [2];
    logic       fd [2];
    typedef struct packed {
        logic b;
        logic last;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    always #5 clk = ~clk;
    seq_bit_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(2)) u0 (
        .clk(clk), .rst_n(rst_n), .data_in(din[0]), .data_valid(dv[0]), .abort(ab[0]),
        .data_ready(dr[0]), .C(c[0]), .c_valid(cv[0]), .frame_done(fd[0])
    );
    seq_bit_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(0)) u1 (
        .clk(clk), .rst_n(rst_n), .data_in(din[1]), .data_valid(dv[1]), .abort(ab[1]),
        .data_ready(dr[1]), .C(c[1]), .c_valid(cv[1]), .frame_done(fd[1])
    );
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic push(int i, logic [7:0] w, bit msb);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.b    = msb ? w[7-k] : w[k];
            e.last = k == 7;
            if (i == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic run_frame(int i, logic [7:0] w, int gap, bit msb);
        din[i] = w;
        dv[i]  = 1'b1;
        push(i, w, msb);
        check($sformatf("u%0d_ready_pre", i), 32'(dr[i]), 32'd1);
        cyc();
        dv[i] = 1'b0;
        for (int k = 1; k <= 9 + gap; k++) begin
            @(negedge clk);
            check($sformatf("u%0d_ready_c%0d", i, k), 32'(dr[i]), 32'(k > 8 + gap));
            check($sformatf("u%0d_valid_c%0d", i, k), 32'(cv[i]), 32'(k <= 8));
            cyc();
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                if (cv[i]) begin
                    if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                        check($sformatf("u%0d_unexpected_bit", i), 32'(cv[i]), 32'd0);
                    end else begin
                        if (i == 0) e = q0.pop_front();
                        else e = q1.pop_front();
                        check($sformatf("u%0d_bit", i), 32'(c[i]), 32'(e.b));
                        check($sformatf("u%0d_frame_done", i), 32'(fd[i]), 32'(e.last));
                    end
                end else begin
                    check($sformatf("u%0d_c_idle", i), 32'(c[i]), 32'd0);
                    check($sformatf("u%0d_fd_idle", i), 32'(fd[i]), 32'd0);
                end
            end
        end
    end
    initial begin
        int fd1;
        int fd2;
        fd1   = -1;
        fd2   = -1;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            din[i] = '0;
            dv[i]  = 1'b0;
            ab[i]  = 1'b0;
        end
        cyc();
        cyc();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check($sformatf("u%0d_rst_valid", i), 32'(cv[i]), 32'd0);
                check($sformatf("u%0d_rst_ready", i), 32'(dr[i]), 32'd1);
            end
            cyc();
        end
        run_frame(0, 8'hB2, 2, 1'b1);
        run_frame(1, 8'hB2, 0, 1'b0);
        din[1] = 8'hFF;
        dv[1]  = 1'b1;
        push(1, 8'hFF, 1'b0);
        push(1, 8'h00, 1'b0);
        cyc();
        din[1] = 8'h00;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (fd[1]) begin
                if (fd1 < 0) fd1 = k;
                else fd2 = k;
            end
            if (k == 9) begin
                check("b2b_gap_valid", 32'(cv[1]), 32'd0);
                check("b2b_ready_c9", 32'(dr[1]), 32'd1);
            end
            if (k == 10) check("b2b_valid_c10", 32'(cv[1]), 32'd1);
            cyc();
            if (k == 9) dv[1] = 1'b0;
        end
        check("b2b_fd_first", 32'(fd1), 32'd8);
        check("b2b_fd_spacing", 32'(fd2 - fd1), 32'd9);
        din[0] = 8'hA7;
        dv[0]  = 1'b1;
        push(0, 8'hA7, 1'b1);
        cyc();
        dv[0] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("abort_busy_ready_c%0d", k), 32'(dr[0]), 32'd0);
            cyc();
            if (k == 1) begin
                din[0] = 8'h55;
                dv[0]  = 1'b1;
            end
            if (k == 2) dv[0] = 1'b0;
            if (k == 3) ab[0] = 1'b1;
            if (k == 4) begin
                ab[0] = 1'b0;
                q0.delete();
            end
        end
        for (int k = 5; k <= 14; k++) begin
            @(negedge clk);
            check($sformatf("abort_valid_c%0d", k), 32'(cv[0]), 32'd0);
            check($sformatf("abort_ready_c%0d", k), 32'(dr[0]), 32'd1);
            cyc();
        end
        din[0] = 8'hAA;
        dv[0]  = 1'b1;
        ab[0]  = 1'b1;
        cyc();
        dv[0] = 1'b0;
        ab[0] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("idle_abort_valid_c%0d", k), 32'(cv[0]), 32'd0);
            check($sformatf("idle_abort_ready_c%0d", k), 32'(dr[0]), 32'd1);
            cyc();
        end
        din[0] = 8'hC3;
        dv[0]  = 1'b1;
        push(0, 8'hC3, 1'b1);
        cyc();
        dv[0] = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b0;
        cyc();
        q0.delete();
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_c", 32'(c[0]), 32'd0);
        check("midrst_valid", 32'(cv[0]), 32'd0);
        check("midrst_fd", 32'(fd[0]), 32'd0);
        check("midrst_ready", 32'(dr[0]), 32'd1);
        cyc();
        run_frame(0, 8'h3C, 2, 1'b1);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_bit_tx.md
Name: seq_bit_tx

Overview:
Serial sequence transmitter. It takes a parallel word via a valid/ready handshake and drives it one bit per clock onto the serial line C, framed by c_valid. It is the stimulus/transmit end feeding the single-bit sequence-detector blocks, which consume C. It also serves as a reusable pattern source in benches.

Parameters:
WIDTH, 8, bits per frame (legal range 2..32)
MSB_FIRST, 1, 1 = data_in[WIDTH-1] sent first; 0 = data_in[0] sent first
GAP, 1, idle cycles inserted after each frame before data_ready reasserts (legal range 0..15)

Ports:
clk  input  1  clock
rst_n  input  1  reset; synchronous, active-low
data_in  input  WIDTH  parallel word to send
data_valid  input  1  data_in valid; accepted when data_valid && data_ready at a rising edge
abort  input  1  synchronous cancel of the frame in progress
data_ready  output  1  block can accept a word; high only in IDLE
C  output  1  serial data bit, registered
c_valid  output  1  C carries a frame bit, registered
frame_done  output  1  one-cycle pulse coincident with the last bit of a frame, registered

Behaviour:
- Reset (rst_n low at a rising edge): state=IDLE, C=0, c_valid=0, frame_done=0, shift register and counters cleared. data_ready=1 from the cycle after reset.
- Priority at every edge: reset > abort > handshake/advance.
- FSM has three states: IDLE, SHIFT, GAP. data_ready is decoded as (state==IDLE).
- IDLE:
  - On handshake at edge E0: capture data_in into the shift register; state=SHIFT; bit counter=0.
  - After E0: C = first bit (MSB if MSB_FIRST), c_valid=1.
  - data_valid while not IDLE is ignored. Data is not buffered.
- SHIFT:
  - Each edge advances one bit. After edge Ek (k=0..WIDTH-1), C holds frame bit k.
  - After E(WIDTH-1): C holds the last bit and frame_done=1 in that same cycle.
  - At E(WIDTH): c_valid=0, C=0, frame_done=0.
  - Next state is GAP if GAP>0, else IDLE.
- GAP: C=0, c_valid=0 for exactly GAP cycles, then IDLE.
- Latency and throughput:
  - First bit appears 1 cycle after the handshake.
  - Frame occupies WIDTH cycles.
  - Handshake-to-handshake minimum is WIDTH+GAP+1 cycles (the IDLE cycle is included).
- abort high at an edge:
  - State goes to IDLE; C=0, c_valid=0, frame_done=0 next cycle.
  - No frame_done is produced for the cancelled frame.
  - A data_valid in the same cycle as abort is not accepted.
  - abort in IDLE has no effect.
- Reset mid-frame behaves like abort and also clears all state.
- While c_valid=0, C is held at 0.
- Widths:
  - Bit counter is $clog2(WIDTH) bits; it terminates at WIDTH-1 (no wrap past it).
  - Gap counter is $clog2(GAP+1) bits, minimum 1.
- No combinational path from any input to any output except data_in/data_valid → nothing. data_ready depends on state only.

Decomposition:
- Shared package seq_pkg holds the state encoding (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2) and the default WIDTH/GAP constants, so detector and transmitter benches agree.
- One sub-module is natural: seq_shift_out, a parameterised loadable shift register with MSB_FIRST select, load and shift enables. The FSM and counters stay in seq_bit_tx.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release → C=0, c_valid=0, frame_done=0, data_ready=1; no activity without data_valid.
- Basic frame, WIDTH=8, MSB_FIRST=1, GAP=2, data_in=8'hB2 → C=1,0,1,1,0,0,1,0 on cycles 1..8 after the handshake with c_valid=1; frame_done only on cycle 8; C=0 on cycles 9–10; data_ready=1 from cycle 11.
- LSB-first, MSB_FIRST=0, data_in=8'hB2 → C=0,1,0,0,1,1,0,1.
- Back-to-back, GAP=0, data_valid held high with words 8'hFF then 8'h00 → second handshake on cycle 9; C=0 for exactly one cycle between frames; two frame_done pulses 9 cycles apart.
- Abort and busy-ignore: abort on cycle 4 of a frame → c_valid=0 from cycle 5, no frame_done, data_ready=1 in cycle 5. data_valid pulsed mid-frame with 8'h55 is not sent. Abort and data_valid together in IDLE → no frame is started.
- Reset mid-frame: rst_n=0 on cycle 3 → all outputs return to reset values next cycle; a new frame after release transmits correctly.
